// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO sequential divider: state encodings,
// divide-by-zero quotient pattern and the datapath width common with the multiplier.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_SIGN = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_DIV  = ST_DIV,
        S_SIGN = ST_SIGN,
        S_DONE = ST_DONE
    } div_state_e;

    // Quotient reported when the divisor is zero (all ones at any width).
    localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder needs one extra bit so the compare is exact.
    logic [WIDTH:0] t;

    always_comb begin
        t        = {rem, quo_msb};
        q_bit    = (t >= {1'b0, divisor});
        rem_next = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/div.sv
// Sequential restoring divider for DIV/DIVU: quotient to LO, remainder to HI,
// one quotient bit per clock with a start/busy/done handshake.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output div_state_e       dbg_state
);

    // Handshake: start is sampled only in IDLE (busy low); A/B must stay stable
    // through the following LOAD cycle; done is a one-cycle pulse coincident
    // with the first cycle HI/LO/div_zero show the new result.

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state, state_d;
    logic             sgn, sgn_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             dz, dz_d;
    // Remainder stays below the divisor between iterations, so WIDTH bits hold it.
    logic [WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0] quo, quo_d;
    logic [WIDTH-1:0] dvs, dvs_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             done_d, div_zero_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo_msb  (quo[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        a_mag = (sgn && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag = (sgn && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
    end

    always_comb begin
        state_d    = state;
        sgn_d      = sgn;
        neg_q_d    = neg_q;
        neg_r_d    = neg_r;
        dz_d       = dz;
        rem_d      = rem;
        quo_d      = quo;
        dvs_d      = dvs;
        cnt_d      = cnt;
        hi_d       = HI;
        lo_d       = LO;
        div_zero_d = div_zero;
        done_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    sgn_d   = is_signed;
                end
            end
            S_LOAD: begin
                if (B == '0) begin
                    // Divide by zero skips iteration and sign fix-up entirely.
                    rem_d   = A;
                    quo_d   = {WIDTH{DIV_ZERO_QUO[0]}};
                    dz_d    = 1'b1;
                    neg_q_d = 1'b0;
                    neg_r_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    neg_q_d = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r_d = sgn & A[WIDTH-1];
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                quo_d = {quo[WIDTH-2:0], step_bit};
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                if (neg_q) quo_d = -quo;
                if (neg_r) rem_d = -rem;
                state_d = S_DONE;
            end
            S_DONE: begin
                hi_d       = rem;
                lo_d       = quo;
                div_zero_d = dz;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sgn      <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            HI       <= '0;
            LO       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_d;
            sgn      <= sgn_d;
            neg_q    <= neg_q_d;
            neg_r    <= neg_r_d;
            dz       <= dz_d;
            rem      <= rem_d;
            quo      <= quo_d;
            dvs      <= dvs_d;
            cnt      <= cnt_d;
            HI       <= hi_d;
            LO       <= lo_d;
            done     <= done_d;
            div_zero <= div_zero_d;
        end
    end

endmodule
